// File: rtl/bin_bcd_seq_if.sv
// Start/busy/done handshake and data bundle for the sequential binary-to-BCD converter.
// The master side requests conversions; the slave side is the converter.
interface bin_bcd_seq_if #(
   parameter int BIN_W  = 7,
   parameter int DIGITS = 2
) ();
   logic                  start;
   logic [BIN_W-1:0]      bin_in;
   logic                  sel_hora;
   logic                  SF_24_12;
   logic                  SF_AM_PM;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd_out;
   logic                  ovf;

   modport master (
      output start, bin_in, sel_hora, SF_24_12, SF_AM_PM,
      input  busy, done, bcd_out, ovf
   );

   modport slave (
      input  start, bin_in, sel_hora, SF_24_12, SF_AM_PM,
      output busy, done, bcd_out, ovf
   );
endinterface

// File: rtl/bin_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock, with 12h hour flag.
// Optional macro HOUR_24_TO_12_EN: remaps 24h hour input to 12h and derives the AM/PM flag.
module bin_bcd_seq #(
   parameter int BIN_W  = 7,
   parameter int DIGITS = 2
) (
   input  logic              clk,
   input  logic              reset,
   bin_bcd_seq_if.slave      bus
);
   localparam int unsigned MAX_VAL = 10**DIGITS - 1;
   localparam int ACC_W = 4*DIGITS + 4;
   localparam int OUT_W = 4*DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int EXT_W = BIN_W + 32;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t             state, state_next;
   logic [ACC_W-1:0]   acc, acc_next, acc_adj;
   logic [BIN_W-1:0]   shreg, shreg_next, load_val;
   logic [CNT_W-1:0]   cnt, cnt_next;
   logic               ovf_cap, ovf_cap_next;
   logic               hour_cap, hour_cap_next;
   logic               ampm_cap, ampm_cap_next;
   logic               busy, busy_next;
   logic               done, done_next;
   logic [OUT_W-1:0]   bcd, bcd_next;
   logic               ovf, ovf_next;
   logic [EXT_W-1:0]   raw_ext;
   logic               ovf_in, hour_in, ampm_in;

   // State and datapath registers; reset also aborts any conversion in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         acc      <= '0;
         shreg    <= '0;
         cnt      <= '0;
         ovf_cap  <= 1'b0;
         hour_cap <= 1'b0;
         ampm_cap <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         bcd      <= '0;
         ovf      <= 1'b0;
      end else begin
         state    <= state_next;
         acc      <= acc_next;
         shreg    <= shreg_next;
         cnt      <= cnt_next;
         ovf_cap  <= ovf_cap_next;
         hour_cap <= hour_cap_next;
         ampm_cap <= ampm_cap_next;
         busy     <= busy_next;
         done     <= done_next;
         bcd      <= bcd_next;
         ovf      <= ovf_next;
      end
   end

   // Capture-time decoding, add-3 correction, shifting and result formatting
   always_comb begin
      state_next    = state;
      acc_next      = acc;
      shreg_next    = shreg;
      cnt_next      = cnt;
      ovf_cap_next  = ovf_cap;
      hour_cap_next = hour_cap;
      ampm_cap_next = ampm_cap;
      busy_next     = busy;
      done_next     = 1'b0;
      bcd_next      = bcd;
      ovf_next      = ovf;

      raw_ext  = EXT_W'(bus.bin_in);
      load_val = bus.bin_in;
      ovf_in   = (raw_ext > EXT_W'(MAX_VAL));
      hour_in  = bus.sel_hora & bus.SF_24_12;
      ampm_in  = bus.SF_AM_PM;
`ifdef HOUR_24_TO_12_EN
      // 0 becomes 12 AM, 13..23 fold down by twelve; the flag follows the 24h value
      if (hour_in) begin
         if (raw_ext > EXT_W'(23))
            ovf_in = 1'b1;
         ampm_in = (raw_ext >= EXT_W'(12));
         if (raw_ext == '0)
            load_val = BIN_W'(12);
         else if (raw_ext > EXT_W'(12))
            load_val = bus.bin_in - BIN_W'(12);
      end
`endif

      acc_adj = acc;
      for (int i = 0; i < DIGITS + 1; i++) begin
         if (acc[4*i +: 4] >= 4'd5)
            acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end

      case (state)
         IDLE: begin
            if (bus.start) begin
               shreg_next    = load_val;
               acc_next      = '0;
               cnt_next      = CNT_W'(BIN_W);
               ovf_cap_next  = ovf_in;
               hour_cap_next = hour_in;
               ampm_cap_next = ampm_in;
               busy_next     = 1'b1;
               state_next    = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt != '0) begin
               {acc_next, shreg_next} = {acc_adj, shreg} << 1;
               cnt_next = cnt - CNT_W'(1);
            end else begin
               // Out-of-range values report all zeros, including the hour flag bit
               if (ovf_cap)
                  bcd_next = '0;
               else if (hour_cap)
                  bcd_next = {ampm_cap, acc[OUT_W-2:0]};
               else
                  bcd_next = acc[OUT_W-1:0];
               ovf_next   = ovf_cap;
               done_next  = 1'b1;
               busy_next  = 1'b0;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.busy    = busy;
   assign bus.done    = done;
   assign bus.bcd_out = bcd;
   assign bus.ovf     = ovf;
endmodule

// File: tb/tb_bin_bcd_seq.sv
// Randomized scoreboard bench for bin_bcd_seq: accepted requests queue decimal-model results,
// a negedge monitor compares every done pulse, the held outputs and busy against them.
module tb_bin_bcd_seq;
   localparam int BIN_W   = 7;
   localparam int DIGITS  = 2;
   localparam int MAX_VAL = 99;
   localparam int LAT     = BIN_W + 1;

   typedef struct {
      logic [7:0] bcd;
      logic       ovf;
      int         done_edge;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc = 0;
   int   free_at = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];
   logic [7:0] last_bcd = 8'h00;
   logic       last_ovf = 1'b0;

   bin_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

   bin_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Decimal reference: hours folded with modulo arithmetic, digits from divide/modulo
   function automatic logic [8:0] refModel(input int raw, input bit sel, input bit f12, input bit ampm);
      int         v;
      bit         pm;
      bit         hour12;
      logic [7:0] res;
      v      = raw;
      pm     = ampm;
      hour12 = sel && f12;
`ifdef HOUR_24_TO_12_EN
      if (hour12) begin
         if (raw > 23) return {1'b1, 8'h00};
         pm = (raw >= 12);
         v  = (raw % 12 == 0) ? 12 : raw % 12;
      end
`endif
      if (v > MAX_VAL) return {1'b1, 8'h00};
      res = 8'((v / 10) * 16 + (v % 10));
      if (hour12) res[7] = pm;
      return {1'b0, res};
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s at edge %0d: actual=0x%0h required=0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic driveCycle(input bit st, input int v, input bit sel, input bit f12, input bit ampm);
      bus.start    = st;
      bus.bin_in   = 7'(v);
      bus.sel_hora = sel;
      bus.SF_24_12 = f12;
      bus.SF_AM_PM = ampm;
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input int v, input bit sel, input bit f12, input bit ampm);
      driveCycle(1'b1, v, sel, f12, ampm);
   endtask

   // Idle cycles keep wiggling the data inputs, which must not disturb a conversion
   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++)
         driveCycle(1'b0, $urandom_range(0, 127), 1'($urandom), 1'($urandom), 1'($urandom));
   endtask

   task automatic pulseReset();
      bus.start = 1'b0;
      reset = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b1;
   endtask

   // Acceptance model: a request is taken when the previous result has been delivered
   always @(posedge clk) begin
      logic [8:0] r;
      cyc = cyc + 1;
      if (!reset) begin
         free_at = 0;
      end else if (bus.start && cyc >= free_at) begin
         r = refModel(int'(bus.bin_in), bus.sel_hora, bus.SF_24_12, bus.SF_AM_PM);
         sb.push_back('{bcd: r[7:0], ovf: r[8], done_edge: cyc + LAT});
         free_at = cyc + LAT + 1;
      end
   end

   // Monitor: done only on the predicted edge, outputs held in between
   always @(negedge clk) begin
      if (!reset) begin
         checkOutput("reset_busy", int'(bus.busy), 0);
         checkOutput("reset_done", int'(bus.done), 0);
         checkOutput("reset_bcd", int'(bus.bcd_out), 0);
         checkOutput("reset_ovf", int'(bus.ovf), 0);
         sb.delete();
         last_bcd = 8'h00;
         last_ovf = 1'b0;
      end else begin
         checkOutput("busy", int'(bus.busy), int'(cyc < free_at - 1));
         if (sb.size() > 0 && sb[0].done_edge == cyc) begin
            checkOutput("done_latency", int'(bus.done), 1);
            checkOutput("bcd_result", int'(bus.bcd_out), int'(sb[0].bcd));
            checkOutput("ovf_result", int'(bus.ovf), int'(sb[0].ovf));
            last_bcd = sb[0].bcd;
            last_ovf = sb[0].ovf;
            void'(sb.pop_front());
         end else begin
            checkOutput("done_idle", int'(bus.done), 0);
            checkOutput("bcd_hold", int'(bus.bcd_out), int'(last_bcd));
            checkOutput("ovf_hold", int'(bus.ovf), int'(last_ovf));
         end
      end
   end

   initial begin
      int r;
      bus.start    = 1'b0;
      bus.bin_in   = '0;
      bus.sel_hora = 1'b0;
      bus.SF_24_12 = 1'b0;
      bus.SF_AM_PM = 1'b0;
      reset = 1'b1;
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      idleCycles(2);

      applyStimulus(59, 1'b0, 1'b0, 1'b0);  idleCycles(9);
      applyStimulus(99, 1'b0, 1'b0, 1'b0);  idleCycles(9);
      applyStimulus(100, 1'b0, 1'b0, 1'b0); idleCycles(9);
      applyStimulus(127, 1'b0, 1'b0, 1'b0); idleCycles(9);
      applyStimulus(0, 1'b0, 1'b0, 1'b0);   idleCycles(9);
      applyStimulus(11, 1'b1, 1'b1, 1'b1);  idleCycles(9);
      applyStimulus(11, 1'b1, 1'b0, 1'b1);  idleCycles(9);
      applyStimulus(99, 1'b1, 1'b1, 1'b0);  idleCycles(9);
      applyStimulus(120, 1'b1, 1'b1, 1'b1); idleCycles(9);
`ifdef HOUR_24_TO_12_EN
      applyStimulus(0, 1'b1, 1'b1, 1'b0);   idleCycles(9);
      applyStimulus(15, 1'b1, 1'b1, 1'b0);  idleCycles(9);
      applyStimulus(12, 1'b1, 1'b1, 1'b0);  idleCycles(9);
      applyStimulus(24, 1'b1, 1'b1, 1'b0);  idleCycles(9);
`endif

      // Ignored restart mid-conversion, then a back-to-back start during the done cycle
      applyStimulus(42, 1'b0, 1'b0, 1'b0);
      idleCycles(2);
      applyStimulus(7, 1'b0, 1'b0, 1'b0);
      idleCycles(5);
      applyStimulus(7, 1'b0, 1'b0, 1'b0);
      idleCycles(9);

      applyStimulus(59, 1'b0, 1'b0, 1'b0);
      idleCycles(3);
      pulseReset();
      idleCycles(12);

      for (int i = 0; i < 800; i++) begin
         r = $urandom_range(0, 199);
         if (r == 0)
            pulseReset();
         else if (r < 80)
            applyStimulus(($urandom_range(0, 2) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 30),
                          1'($urandom), 1'($urandom), 1'($urandom));
         else
            idleCycles(1);
      end
      idleCycles(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
